// File: rtl/uarc_io_pkg.sv
// ---------------------------------------------------------------------------
// uarc_io_pkg
// Shared definitions for the UARC board I/O block: the switch-event FSM
// state type and the default parameter values used by uarc_board_io and
// switch_debounce.
// No ports (package).
// ---------------------------------------------------------------------------
package uarc_io_pkg;

    // Switch-event FSM: IDLE waits for a new debounced value, SEND holds a
    // request toward the core until it is acknowledged.
    typedef enum logic {
        EVT_IDLE = 1'b0,
        EVT_SEND = 1'b1
    } evt_state_t;

    localparam int DEF_WORD_MAG        = 5;
    localparam int DEF_CHANNELS        = 1;
    localparam int DEF_OUT_WIDTH       = 16;
    localparam int DEF_IN_WIDTH        = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 65535;
    localparam int DEF_MASK_EN         = 1;

endpackage

// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
// Brings the asynchronous board switches into the clock domain through a
// two-flop synchroniser, then only accepts a new value once it has been
// stable for DEBOUNCE_CYCLES cycles.
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   synchronous active-high reset
//   i_switches   in   IN_WIDTH raw switch inputs (asynchronous)
//   o_debounced  out  IN_WIDTH debounced, synchronous switch value
// ---------------------------------------------------------------------------
module switch_debounce
    import uarc_io_pkg::*;
#(
    parameter int IN_WIDTH        = DEF_IN_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] i_switches,
    output logic [IN_WIDTH-1:0] o_debounced
);

    localparam int CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [IN_WIDTH-1:0] r_sync1;
    logic [IN_WIDTH-1:0] r_sync2;
    logic [IN_WIDTH-1:0] r_debounced;
    logic [CntW-1:0]     r_count;

    // Synchroniser plus stability counter. A difference between the two
    // synchroniser stages means the synchronised value changes at this very
    // edge, so the counter restarts in step with that change rather than one
    // cycle later. Once the count reaches its terminal value it parks there
    // and keeps reloading the (unchanged) synchronised value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_debounced <= '0;
            r_count     <= '0;
        end else begin
            r_sync1 <= i_switches;
            r_sync2 <= r_sync1;
            if (r_sync1 != r_sync2) begin
                r_count <= '0;
            end else if (r_count == CntMax) begin
                r_debounced <= r_sync2;
            end else begin
                r_count <= r_count + CntW'(1);
            end
        end
    end

    assign o_debounced = r_debounced;

endmodule

// File: rtl/uarc_board_io.sv
// ---------------------------------------------------------------------------
// uarc_board_io
// Board I/O peripheral. Each sender bus owns an OUT_WIDTH output register
// (driven onto leds) that the core loads with a send or XORs with a stream,
// optionally masked by the debounced switches. Bus 0 additionally reports
// every new debounced switch value to the core through a send/ack handshake.
// Ports:
//   clk, reset                 sole clock, synchronous active-high reset
//   global_send/global_stream  core send and stream strobes
//   global_data                W-bit word from the core
//   sender_enables             per-bus selection by the core
//   sender_send_acks           per-bus one-cycle send acknowledge
//   sender_stream_acks         per-bus one-cycle stream acknowledge
//   receiver_sends             send request toward the core (bus 0 only)
//   receiver_send_acks         core acknowledge of receiver_sends
//   receiver_datas             W-bit word per bus (bus 0 = switch snapshot)
//   switches                   asynchronous board switches
//   leds                       concatenated output registers
// ---------------------------------------------------------------------------
module uarc_board_io
    import uarc_io_pkg::*;
#(
    parameter int WORD_MAG        = DEF_WORD_MAG,
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int OUT_WIDTH       = DEF_OUT_WIDTH,
    parameter int IN_WIDTH        = DEF_IN_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int MASK_EN         = DEF_MASK_EN
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 global_send,
    input  logic                                 global_stream,
    input  logic [(1<<WORD_MAG)-1:0]             global_data,
    input  logic [CHANNELS-1:0]                  sender_enables,
    output logic [CHANNELS-1:0]                  sender_send_acks,
    output logic [CHANNELS-1:0]                  sender_stream_acks,
    output logic [CHANNELS-1:0]                  receiver_sends,
    input  logic [CHANNELS-1:0]                  receiver_send_acks,
    output logic [CHANNELS*(1<<WORD_MAG)-1:0]    receiver_datas,
    input  logic [IN_WIDTH-1:0]                  switches,
    output logic [CHANNELS*OUT_WIDTH-1:0]        leds
);

    localparam int W = 1 << WORD_MAG;

    logic [IN_WIDTH-1:0]  w_debounced;
    logic [OUT_WIDTH-1:0] w_mask;
    logic [OUT_WIDTH-1:0] w_payload;
    logic [CHANNELS-1:0]  w_sendAccept;
    logic [CHANNELS-1:0]  w_streamAccept;
    logic                 w_unused;

    logic [CHANNELS-1:0]  r_sendAcks;
    logic [CHANNELS-1:0]  r_streamAcks;
    logic [OUT_WIDTH-1:0] r_outReg [CHANNELS];

    evt_state_t           r_state;
    logic                 r_recvSend;
    logic [IN_WIDTH-1:0]  r_lastSent;
    logic [IN_WIDTH-1:0]  r_snapshot;

    switch_debounce #(
        .IN_WIDTH        (IN_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .i_switches  (switches),
        .o_debounced (w_debounced)
    );

    // Write data for every bus: the low OUT_WIDTH bits of the core word,
    // optionally gated by the debounced switches zero-extended to the
    // register width.
    assign w_mask    = (MASK_EN != 0) ? OUT_WIDTH'(w_debounced) : '1;
    assign w_payload = global_data[OUT_WIDTH-1:0] & w_mask;

    // A pending ack blocks a fresh accept, which limits each bus to one
    // transfer every two cycles while a request is held. Send has priority
    // over stream on the same bus; the losing stream simply stays pending.
    assign w_sendAccept   = {CHANNELS{global_send}} & sender_enables & ~r_sendAcks;
    assign w_streamAccept = {CHANNELS{global_stream}} & sender_enables
                          & ~r_streamAcks & ~w_sendAccept;

    // Output registers and their one-cycle acknowledge pulses. Load or XOR
    // happens on the accepting edge, the ack is visible the cycle after.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sendAcks   <= '0;
            r_streamAcks <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_outReg[i] <= '0;
            end
        end else begin
            r_sendAcks   <= w_sendAccept;
            r_streamAcks <= w_streamAccept;
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_sendAccept[i]) begin
                    r_outReg[i] <= w_payload;
                end else if (w_streamAccept[i]) begin
                    r_outReg[i] <= r_outReg[i] ^ w_payload;
                end
            end
        end
    end

    // Switch-event FSM for bus 0. The debounced value is captured into a
    // snapshot on entry to SEND so the offered word stays stable while the
    // core is slow to acknowledge. last_sent only advances on the ack, so a
    // change that arrived meanwhile is seen as new on the first IDLE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= EVT_IDLE;
            r_recvSend <= 1'b0;
            r_lastSent <= '0;
            r_snapshot <= '0;
        end else begin
            case (r_state)
                EVT_IDLE: begin
                    if (w_debounced != r_lastSent) begin
                        r_snapshot <= w_debounced;
                        r_recvSend <= 1'b1;
                        r_state    <= EVT_SEND;
                    end
                end
                EVT_SEND: begin
                    if (receiver_send_acks[0]) begin
                        r_lastSent <= r_snapshot;
                        r_recvSend <= 1'b0;
                        r_state    <= EVT_IDLE;
                    end
                end
                default: begin
                    r_recvSend <= 1'b0;
                    r_state    <= EVT_IDLE;
                end
            endcase
        end
    end

    // Only bus 0 has a receiver; the remaining buses are tied to zero.
    always_comb begin
        receiver_sends         = '0;
        receiver_sends[0]      = r_recvSend;
        receiver_datas         = '0;
        receiver_datas[W-1:0]  = W'(r_snapshot);
    end

    // Flatten the per-bus output registers onto the led vector.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_leds
        assign leds[g*OUT_WIDTH +: OUT_WIDTH] = r_outReg[g];
    end

    assign sender_send_acks   = r_sendAcks;
    assign sender_stream_acks = r_streamAcks;

    // Upper data bits and the acks of buses without a receiver are
    // intentionally ignored.
    assign w_unused = ^{global_data, receiver_send_acks};

endmodule

// File: tb/tb_uarc_board_io.sv
// ---------------------------------------------------------------------------
// tb_uarc_board_io
// Self-checking bench for uarc_board_io with two buses, masking enabled and
// a short debounce. Stimulus pushes the expected response into a queue and
// an independent monitor pops and compares it whenever the DUT raises an
// acknowledge or a new receiver request.
// ---------------------------------------------------------------------------
module tb_uarc_board_io;

    localparam int W  = 32;
    localparam int CH = 2;
    localparam int OW = 16;
    localparam int IW = 16;

    localparam int KIND_SEND   = 0;
    localparam int KIND_STREAM = 1;
    localparam int KIND_EVENT  = 2;

    logic              clk;
    logic              reset;
    logic              global_send;
    logic              global_stream;
    logic [W-1:0]      global_data;
    logic [CH-1:0]     sender_enables;
    logic [CH-1:0]     sender_send_acks;
    logic [CH-1:0]     sender_stream_acks;
    logic [CH-1:0]     receiver_sends;
    logic [CH-1:0]     receiver_send_acks;
    logic [CH*W-1:0]   receiver_datas;
    logic [IW-1:0]     switches;
    logic [CH*OW-1:0]  leds;

    typedef struct {
        int          kind;
        int          ch;
        logic [63:0] value;
    } expect_t;

    expect_t sbQueue[$];
    int      compared   = 0;
    int      mismatched = 0;

    uarc_board_io #(
        .WORD_MAG        (5),
        .CHANNELS        (CH),
        .OUT_WIDTH       (OW),
        .IN_WIDTH        (IW),
        .DEBOUNCE_CYCLES (4),
        .MASK_EN         (1)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .global_send        (global_send),
        .global_stream      (global_stream),
        .global_data        (global_data),
        .sender_enables     (sender_enables),
        .sender_send_acks   (sender_send_acks),
        .sender_stream_acks (sender_stream_acks),
        .receiver_sends     (receiver_sends),
        .receiver_send_acks (receiver_send_acks),
        .receiver_datas     (receiver_datas),
        .switches           (switches),
        .leds               (leds)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectOutput(input int kind, input int ch, input logic [63:0] value);
        expect_t e;
        e.kind  = kind;
        e.ch    = ch;
        e.value = value;
        sbQueue.push_back(e);
    endtask

    task automatic scoreboardPop(input int kind, input int ch, input logic [63:0] value,
                                 input string name);
        expect_t e;
        if (sbQueue.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: unexpected output kind %0d bus %0d value 0x%0h, expected none",
                     name, kind, ch, value);
        end else begin
            e = sbQueue.pop_front();
            checkOutput({name, "_source"}, 64'(kind * 16 + ch), 64'(e.kind * 16 + e.ch));
            checkOutput({name, "_value"}, value, e.value);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic send, input logic stream,
                                 input logic [CH-1:0] en, input logic [W-1:0] data);
        global_send    = send;
        global_stream  = stream;
        sender_enables = en;
        global_data    = data;
    endtask

    task automatic waitEvent(output int cycles);
        cycles = 0;
        while (receiver_sends[0] !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        if (receiver_sends[0] !== 1'b1) begin
            checkOutput("evt_timeout", 64'(receiver_sends), 64'h1);
        end
    endtask

    task automatic ackEvent();
        receiver_send_acks = 2'b01;
        tick();
        receiver_send_acks = 2'b00;
        checkOutput("evt_drop", 64'(receiver_sends), 64'h0);
    endtask

    task automatic settleSwitches(input logic [IW-1:0] value);
        int n;
        expectOutput(KIND_EVENT, 0, 64'(value));
        switches = value;
        waitEvent(n);
        ackEvent();
    endtask

    // Monitor: pops the scoreboard on every ack pulse and on each rising
    // receiver request, sampling mid-cycle on the falling edge.
    initial begin : monitor
        logic prevRs;
        prevRs = 1'b0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if (sender_send_acks[c] === 1'b1)
                    scoreboardPop(KIND_SEND, c, 64'(leds), "sb_send");
                if (sender_stream_acks[c] === 1'b1)
                    scoreboardPop(KIND_STREAM, c, 64'(leds), "sb_stream");
            end
            if (receiver_sends[0] === 1'b1 && !prevRs)
                scoreboardPop(KIND_EVENT, 0, receiver_datas, "sb_event");
            prevRs = (receiver_sends[0] === 1'b1);
        end
    end

    initial begin : stimulus
        int n;

        reset              = 1'b1;
        switches           = '0;
        receiver_send_acks = '0;
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        repeat (3) tick();
        reset = 1'b0;
        checkOutput("rst_leds", 64'(leds), 64'h0);
        checkOutput("rst_acks", 64'({sender_send_acks, sender_stream_acks}), 64'h0);
        checkOutput("rst_rsends", 64'(receiver_sends), 64'h0);
        checkOutput("rst_rdatas", receiver_datas, 64'h0);

        // Debounce latency: 2 sync + 4 stable + 1 FSM cycles.
        expectOutput(KIND_EVENT, 0, 64'h3);
        switches = 16'h0003;
        waitEvent(n);
        checkOutput("evt_latency", 64'(n), 64'd7);
        repeat (5) tick();
        checkOutput("evt_hold_req", 64'(receiver_sends), 64'h1);
        checkOutput("evt_hold_data", receiver_datas, 64'h3);
        ackEvent();

        // Two-cycle glitch must not produce a new request.
        switches = 16'h7FFF;
        repeat (2) tick();
        switches = 16'h0003;
        repeat (15) tick();
        checkOutput("glitch_nosend", 64'(receiver_sends), 64'h0);

        // Full mask, then send on bus 1 only.
        settleSwitches(16'hFFFF);
        expectOutput(KIND_SEND, 1, 64'hA5A5_0000);
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h0000_A5A5);
        tick();
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        checkOutput("send1_acks", 64'(sender_send_acks), 64'h2);
        checkOutput("send1_leds", 64'(leds), 64'hA5A5_0000);
        tick();
        checkOutput("send1_ackpulse", 64'(sender_send_acks), 64'h0);

        // Mask 0x00FF: send then stream on bus 0.
        settleSwitches(16'h00FF);
        expectOutput(KIND_SEND, 0, 64'hA5A5_00FF);
        applyStimulus(1'b1, 1'b0, 2'b01, 32'h0000_FFFF);
        tick();
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        tick();
        expectOutput(KIND_STREAM, 0, 64'hA5A5_00F0);
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h0000_000F);
        tick();
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        tick();

        // Send and stream together: send wins, stream acks afterwards.
        expectOutput(KIND_SEND, 0, 64'hA5A5_0034);
        expectOutput(KIND_STREAM, 0, 64'hA5A5_00C4);
        applyStimulus(1'b1, 1'b1, 2'b01, 32'h0000_1234);
        tick();
        checkOutput("prio_send_ack", 64'(sender_send_acks), 64'h1);
        checkOutput("prio_no_stream_ack", 64'(sender_stream_acks), 64'h0);
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h0000_00F0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        checkOutput("prio_stream_ack", 64'(sender_stream_acks), 64'h1);
        tick();

        // Held send on bus 1: accepted every other cycle.
        expectOutput(KIND_SEND, 1, 64'h000F_00C4);
        expectOutput(KIND_SEND, 1, 64'h000F_00C4);
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h0000_0F0F);
        tick();
        checkOutput("held_ack_c1", 64'(sender_send_acks), 64'h2);
        tick();
        checkOutput("held_ack_c2", 64'(sender_send_acks), 64'h0);
        tick();
        checkOutput("held_ack_c3", 64'(sender_send_acks), 64'h2);
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        tick();

        // Change during SEND is deferred until after the ack.
        expectOutput(KIND_EVENT, 0, 64'h1);
        switches = 16'h0001;
        waitEvent(n);
        switches = 16'h0002;
        expectOutput(KIND_EVENT, 0, 64'h2);
        repeat (12) tick();
        checkOutput("defer_data", receiver_datas, 64'h1);
        ackEvent();
        tick();
        checkOutput("defer_resend", 64'(receiver_sends), 64'h1);
        checkOutput("defer_resend_data", receiver_datas, 64'h2);
        ackEvent();

        // Reset while an ack pulse is visible.
        expectOutput(KIND_SEND, 0, 64'h000F_0002);
        applyStimulus(1'b1, 1'b0, 2'b01, 32'h0000_00FF);
        tick();
        checkOutput("rstack_pre", 64'(sender_send_acks), 64'h1);
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rstack_acks", 64'({sender_send_acks, sender_stream_acks}), 64'h0);
        checkOutput("rstack_leds", 64'(leds), 64'h0);

        // Switches still read 0x2, so a request comes back; reset it mid-SEND.
        expectOutput(KIND_EVENT, 0, 64'h2);
        waitEvent(n);
        reset    = 1'b1;
        switches = 16'h0000;
        tick();
        reset = 1'b0;
        checkOutput("rstsend_rsends", 64'(receiver_sends), 64'h0);
        checkOutput("rstsend_rdatas", receiver_datas, 64'h0);
        repeat (15) tick();
        checkOutput("rstsend_quiet", 64'({receiver_sends, sender_send_acks, sender_stream_acks}), 64'h0);

        repeat (2) tick();
        checkOutput("sb_drained", 64'(sbQueue.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
